// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives all 8 vectors of a 3-input unit, samples y after HOLD_CYCLES and scores it against a captured truth table.
module tt_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_map
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  state_t     state;
  logic [2:0] vec;
  logic [2:0] abc;
  logic [3:0] hold_cnt;
  logic [7:0] snapshot;
  logic       sample;
  logic       miss;
  assign sample = hold_cnt == HOLD_LAST;
  assign miss = y != snapshot[vec];
  assign {a, b, c} = abc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      hold_cnt  <= '0;
      abc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_map  <= '0;
      snapshot  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= DRIVE;
          busy      <= 1'b1;
          vec       <= '0;
          hold_cnt  <= '0;
          abc       <= '0;
          err_count <= '0;
          fail_map  <= '0;
          pass      <= 1'b0;
          snapshot  <= expected;
        end
        DRIVE: if (abort) begin
          state    <= IDLE;
          busy     <= 1'b0;
          abc      <= '0;
          vec      <= '0;
          hold_cnt <= '0;
        end else if (sample) begin
          if (miss) begin
            fail_map[vec] <= 1'b1;
            err_count     <= err_count + 4'd1;
          end
          hold_cnt <= '0;
          if (vec == 3'd7) begin
            // Final error count includes this last sample, so fold miss in directly
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            abc   <= '0;
            vec   <= '0;
            pass  <= (err_count == 4'd0) && !miss;
          end else begin
            vec <= vec + 3'd1;
            abc <= vec + 3'd1;
          end
        end else begin
          hold_cnt <= hold_cnt + 4'd1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: scoreboarded sweeps of a majority unit on HOLD=4 and HOLD=1 instances.
module tb_tt_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, abort4 = 1'b0, y4;
  logic [7:0] exp4 = '0, fault = '0;
  logic       a4, b4, c4, busy4, done4, pass4;
  logic [3:0] err4;
  logic [7:0] map4;
  logic       start1 = 1'b0, abort1 = 1'b0, y1;
  logic [7:0] exp1 = '0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] map1;
  int tests = 0, fails = 0;
  typedef struct {
    logic [7:0] ev;
    logic [7:0] fault;
    logic [3:0] err;
    logic [7:0] map;
    logic       pass;
    logic       rep;
  } rec_t;
  rec_t tbl[6];
  rec_t sb[$];

  always #5 clk = ~clk;

  // Majority unit; fault flips y while the corresponding vector is driven
  assign y4 = ((a4 & b4) | (a4 & c4) | (b4 & c4)) ^ fault[{a4, b4, c4}];
  assign y1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  tt_sweep_ctrl #(.HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .expected(exp4), .y(y4),
    .a(a4), .b(b4), .c(c4), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_map(map4)
  );
  tt_sweep_ctrl #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_map(map1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic sweep(input rec_t v);
    rec_t r;
    @(negedge clk);
    exp4 = v.ev;
    fault = v.fault;
    start4 = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start4 = 1'b0;
    exp4 = ~v.ev;
    for (int t = 0; t <= 32; t++) begin
      if (t > 0) @(negedge clk);
      start4 = 1'b0;
      if (done4) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: got done=1 expected no pending sweep");
        end else begin
          r = sb.pop_front();
          chk("err", 32'(err4), 32'(r.err));
          chk("map", 32'(map4), 32'(r.map));
          chk("pass", 32'(pass4), 32'(r.pass));
        end
      end
      chk($sformatf("seq t=%0d", t), 32'({done4, busy4, a4, b4, c4, pass4}),
          32'(t < 32 ? {2'b01, 3'(t / 4), 1'b0} : {2'b10, 3'b000, v.pass}));
      if (v.rep && (t == 4 || t == 19)) start4 = 1'b1;
    end
    @(negedge clk);
    chk("idle_hold", 32'({done4, busy4, pass4, err4, map4}), 32'({2'b00, v.pass, v.err, v.map}));
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int cnt;
    tbl[0] = '{8'hE8, 8'h00, 4'd0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'hE8, 8'h20, 4'd1, 8'h20, 1'b0, 1'b0};
    tbl[2] = '{8'h17, 8'h00, 4'd8, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'hE8, 8'h00, 4'd0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{8'hE9, 8'h81, 4'd1, 8'h80, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 4'd4, 8'hE8, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst4", 32'({a4, b4, c4, busy4, done4, pass4, err4, map4}), 0);
    chk("rst1", 32'({a1, b1, c1, busy1, done1, pass1, err1, map1}), 0);
    sweep(tbl[1]);
    // start and abort together in IDLE, then abort while vector 3 is driven
    @(negedge clk);
    exp4 = 8'hE8;
    fault = 8'h02;
    start4 = 1'b1;
    abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    abort4 = 1'b0;
    chk("start_wins", 32'({busy4, pass4, err4, map4}), 32'({1'b1, 1'b0, 4'd0, 8'h00}));
    repeat (13) @(negedge clk);
    chk("vec3", 32'({a4, b4, c4}), 3);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("abort", 32'({done4, busy4, a4, b4, c4, pass4, err4, map4}), 32'({6'b0, 4'd1, 8'h02}));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(done4) + int'(busy4);
    end
    chk("abort_quiet", cnt, 0);
    chk("abort_keep", 32'({err4, map4}), 32'({4'd1, 8'h02}));
    for (int i = 0; i < 6; i++) if (i != 1) sweep(tbl[i]);
    // reset mid-sweep discards partial results
    @(negedge clk);
    exp4 = 8'hE8;
    fault = 8'h02;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst", 32'({busy4, err4, map4}), 32'({1'b1, 4'd1, 8'h02}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid", 32'({a4, b4, c4, busy4, done4, pass4, err4, map4}), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt += int'(done4) + int'(busy4);
    end
    chk("rst_quiet", cnt, 0);
    // HOLD=1 sweep: done 8 edges after start
    @(negedge clk);
    exp1 = 8'hE8;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) @(negedge clk);
      chk($sformatf("h1 t=%0d", t), 32'({done1, busy1, a1, b1, c1, pass1}),
          32'(t < 8 ? {2'b01, 3'(t), 1'b0} : {2'b10, 3'b000, 1'b1}));
    end
    chk("h1_res", 32'({err1, map1}), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
